// File: rtl/backward.sv
// backward: error back-propagation stage, scales one error by N fetched weights
module backward #(
  parameter int W = 16,
  parameter int N = 2,
  parameter int Q = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_e_stb,
  input  logic [W-1:0]    s_e_dat,
  output logic            s_e_rdy,
  input  logic [N-1:0]    m_e_rdy,
  output logic [N-1:0]    m_e_stb,
  output logic [N*W-1:0]  m_e_dat,
  input  logic            m_a_rdy,
  output logic            m_a_stb,
  output logic [IW-1:0]   m_a_dat,
  input  logic            s_d_stb,
  input  logic [W-1:0]    s_d_dat,
  output logic            s_d_rdy
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, OUT} state_t;
  localparam logic signed [2*W-1:0] HI = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] LO = {{(W+1){1'b1}}, {(W-1){1'b0}}};
  state_t state;
  logic [IW-1:0] idx;
  logic [W-1:0] err, res, res_nxt;
  logic signed [2*W-1:0] sh;
  assign m_a_dat = idx;
  assign m_e_dat = {N{res}};
  // Q-format product with floor shift, saturated back to W bits
  always_comb begin
    sh = ($signed(err) * $signed(s_d_dat)) >>> Q;
    res_nxt = sh > HI ? HI[W-1:0] : sh < LO ? LO[W-1:0] : sh[W-1:0];
  end
  // Sequencer: take error, then per input fetch weight and emit scaled error
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      idx <= '0;
      err <= '0;
      res <= '0;
      s_e_rdy <= 1'b1;
      m_a_stb <= 1'b0;
      s_d_rdy <= 1'b0;
      m_e_stb <= '0;
    end else
      case (state)
        IDLE: if (s_e_stb) begin
          err <= s_e_dat;
          idx <= '0;
          s_e_rdy <= 1'b0;
          m_a_stb <= 1'b1;
          state <= ADDR;
        end
        ADDR: if (m_a_rdy) begin
          m_a_stb <= 1'b0;
          s_d_rdy <= 1'b1;
          state <= DATA;
        end
        DATA: if (s_d_stb) begin
          res <= res_nxt;
          s_d_rdy <= 1'b0;
          m_e_stb <= N'(1) << idx;
          state <= OUT;
        end
        OUT: if (m_e_rdy[idx]) begin
          m_e_stb <= '0;
          if (idx == IW'(N-1)) begin
            s_e_rdy <= 1'b1;
            state <= IDLE;
          end else begin
            idx <= idx + 1'b1;
            m_a_stb <= 1'b1;
            state <= ADDR;
          end
        end
      endcase
endmodule

// File: doc/backward.md
# backward

Error back-propagation stage of a neuron: the reverse direction of the forward multiply-accumulate path. Accepts one error sample from the downstream layer and fetches each of the N input weights over the shared weight-memory address/data handshake. Scales the error by each weight in Q-format and returns one propagated error per input connection on N independent output channels. Sits beside the forward stage and shares the same weight memory port style.

## Interface
- W, 16: sample/weight width, signed two's complement.
- N, 2: number of input connections (N >= 2).
- Q, 8: fractional bits of error and weight.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- s_e_stb  in  1  error sample valid.
- s_e_dat  in  W  error sample.
- s_e_rdy  out  1  error sample ready.
- m_e_rdy  in  N  per-input propagated-error ready.
- m_e_stb  out  N  per-input propagated-error valid (one-hot or zero).
- m_e_dat  out  N*W  propagated error, same value on every lane.
- m_a_rdy  in  1  weight address ready.
- m_a_stb  out  1  weight address valid.
- m_a_dat  out  $clog2(N)  weight index.
- s_d_stb  in  1  weight data valid.
- s_d_dat  in  W  weight data.
- s_d_rdy  out  1  weight data ready.

## Operation
- Every channel uses the stb/rdy handshake. A transfer occurs on a rising clk edge with stb & rdy high.
- Once stb is raised, stb and dat hold until the transfer.
- All outputs come from registers (state, idx, err, res); no combinational input-to-output paths.
- FSM states and behaviour:
  - IDLE: s_e_rdy=1. On the error transfer, latch err=s_e_dat, set idx=0, go to ADDR.
  - ADDR: m_a_stb=1, m_a_dat=idx. On m_a_rdy, go to DATA.
  - DATA: s_d_rdy=1. On s_d_stb, latch res=sat(($signed(err)*$signed(s_d_dat))>>>Q), go to OUT.
  - OUT: m_e_stb[idx]=1, all other bits 0.
    - On m_e_rdy[idx] with idx==N-1, go to IDLE.
    - Otherwise idx=idx+1, go to ADDR.
- m_e_rdy bits other than idx are ignored.
- Arithmetic:
  - Full 2W-bit signed product, then arithmetic right shift by Q (truncation toward -inf).
  - Saturate to [-2^(W-1), 2^(W-1)-1].
  - m_e_dat = {N{res}}.
- Weights are requested in ascending index 0..N-1; outputs are issued in the same order.
- idx wraps only through IDLE; it never exceeds N-1.
- Reset values while rst=0:
  - state=IDLE, idx=0, err=0, res=0.
  - s_e_rdy=1, m_a_stb=0, m_a_dat=0, s_d_rdy=0, m_e_stb=0, m_e_dat=0.
  - No transfer is recognised while rst=0.
- Reset asserted mid-operation:
  - Immediate return to IDLE; pending output discarded; all stb/rdy outputs except s_e_rdy drop asynchronously.
  - Next error is accepted on the first edge after rst deasserts.

## Timing
- Error accepted at edge 0 → m_a_stb high in cycle 1.
- Address accepted at edge k → s_d_rdy high in cycle k+1.
- Data accepted at edge k → m_e_stb[idx] and m_e_dat valid in cycle k+1.
- Output accepted at edge k → next ADDR in cycle k+1, or IDLE (s_e_rdy=1) in cycle k+1.
- With all ready inputs and s_d_stb held high: 3 cycles per input. Next error accepted 3N+1 cycles after the previous one (N=2: edges 0 and 7).
- Each stall cycle on m_a_rdy, s_d_stb or m_e_rdy[idx] adds exactly one cycle and leaves outputs unchanged.
- s_e_rdy is low in every non-IDLE state; errors are never queued.

## Test plan
- Basic scaling: W=16, Q=8, N=2, e=0x0100, weights [0x0200, 0xFF00] → m_e_stb=01 with 0x0200, then 10 with 0xFF00. Next s_e_rdy exactly 7 cycles after accept.
- Saturation: e=0x7F00, w0=0x7F00, w1=0x8000 → 0x7FFF, then 0x8000.
- Truncation: e=0x0001, w0=0xFFFF, w1=0x0080 → 0xFFFF (−1), then 0x0000.
- Backpressure: random low cycles on m_a_rdy, s_d_stb and m_e_rdy[idx], plus m_e_rdy held high on the wrong lane.
  - Outputs stay stable while stalled.
  - The wrong lane never completes a transfer.
  - Order remains 0,1; values are unchanged.
- Reset mid-operation: assert rst while in DATA for idx=1 → all stb/rdy outputs except s_e_rdy go 0 immediately and m_e_dat=0.
  - After release, e=0x0200 with weights [0x0100, 0x0100] → 0x0200, 0x0200.
- Address check: for N=4, log m_a_dat across two errors → 0,1,2,3,0,1,2,3, with each address held until m_a_rdy.
